// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int WAIT_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side write port of the UART transmit FIFO (valid/ready byte stream).
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] wr_data;
  logic                   wr_valid;
  logic                   wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);

endinterface

// File: rtl/uart_fifo_ram.sv
// Byte storage for the transmit FIFO: synchronous write, asynchronous read.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DEPTH_LOG2-1:0]  waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0]  raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Contents are never reset; only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus sequencer that feeds uart_tx one byte at a time through its
// tx_data / tx_start / tx_busy handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  uart_tx_fifo_if.slave          wr,
  input  logic                   flush,
  input  logic                   clr_overflow,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy
);

  localparam logic [DEPTH_LOG2:0] DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam int                  TO_W    = $clog2(WAIT_BUSY_TIMEOUT);
  localparam logic [TO_W-1:0]     TO_LAST = TO_W'(WAIT_BUSY_TIMEOUT - 1);

  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [UART_DATA_W-1:0] rd_data;
  seq_state_e             state;
  seq_state_e             state_nxt;
  logic [TO_W-1:0]        to_cnt;
  logic                   wr_en;
  logic                   pop;
  logic                   ovf_set;

  // Flags come from the registered level, so wr_ready has no path from tx_busy.
  assign empty       = (level == '0);
  assign full        = (level == DEPTH);
  assign wr.wr_ready = !full && !flush;
  assign wr_en       = wr.wr_valid && wr.wr_ready;
  assign ovf_set     = wr.wr_valid && full;

  uart_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr.wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointers and occupancy; flush discards everything not yet handed to uart_tx.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (flush) begin
        rd_ptr <= wr_ptr;
        level  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  // Sticky overflow on a write attempt against a full FIFO; a new set beats clear.
  always_ff @(posedge clk) begin
    if (!nrst)             overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  // Sequencer state register plus the WAIT_BUSY watchdog count.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= (state == WAIT_BUSY && state_nxt == WAIT_BUSY) ? to_cnt + 1'b1 : '0;
    end
  end

  // Next state: issue from IDLE, wait for uart_tx to raise busy (or give up), then for it to drop.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!empty && !tx_busy && !flush) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)                state_nxt = WAIT_DONE;
        else if (to_cnt == TO_LAST) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Pop decision: only IDLE issues a byte, and flush suppresses it.
  always_comb begin
    pop = (state == IDLE) && !empty && !tx_busy && !flush;
  end

  // Registered handshake toward uart_tx; the pulse lasts one cycle because pop leaves IDLE.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= pop;
      if (pop) tx_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed sequences, a stimulus table and a random
// phase, all checked against a queue-based model of the FIFO contents.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           flush = 1'b0;
  logic           clr_overflow = 1'b0;
  logic [DL2:0]   level;
  logic           empty, full, overflow, tx_start, tx_busy;
  logic [7:0]     tx_data;

  logic force_hi = 1'b0;
  logic force_lo = 1'b0;
  logic mdl_busy;
  int   mdl_cnt;
  int   busy_len = 40;

  int n_chk = 0, n_fail = 0, n_pulses = 0, n_ff = 0;

  uart_tx_fifo_if bus ();

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .wr           (bus),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy)
  );

  assign tx_busy = force_hi ? 1'b1 : (force_lo ? 1'b0 : mdl_busy);

  // Stand-in for uart_tx: busy rises the cycle after tx_start and lasts busy_len cycles.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= 0;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) mdl_busy <= 1'b0;
    end else if (tx_start) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= busy_len;
    end
  end

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endfunction

  // Reference model: a byte queue updated once per cycle from the inputs seen
  // before the edge. Checked on the falling edge, away from the active edge.
  byte unsigned mq[$];
  logic       p_rst = 1'b1, p_fl = 1'b0, p_wr = 1'b0, p_set = 1'b0, p_clr = 1'b0;
  logic       prev_start = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       m_ovf = 1'b0;

  always @(negedge clk) begin
    if (p_rst) begin
      mq.delete();
      m_ovf = 1'b0;
      chk("rst_tx_start", int'(tx_start), 0);
      chk("rst_tx_data", int'(tx_data), 0);
    end else begin
      if (tx_start) begin
        n_pulses++;
        chk("pop_legal", int'(p_fl || mq.size() == 0), 0);
        chk("pulse_width", int'(prev_start), 0);
        if (tx_data == 8'hFF) n_ff++;
        if (mq.size() != 0) chk("tx_data_order", int'(tx_data), int'(mq.pop_front()));
      end
      if (p_fl) mq.delete();
      else if (p_wr) mq.push_back(p_data);
      if (p_set) m_ovf = 1'b1;
      else if (p_clr) m_ovf = 1'b0;
    end
    chk("mdl_level", int'(level), mq.size());
    chk("mdl_empty", int'(empty), int'(mq.size() == 0));
    chk("mdl_full", int'(full), int'(mq.size() == DEPTH));
    chk("mdl_overflow", int'(overflow), int'(m_ovf));
    chk("mdl_wr_ready", int'(bus.wr_ready), int'(mq.size() < DEPTH && !flush));
    p_rst      = !nrst;
    p_fl       = flush;
    p_wr       = bus.wr_valid && mq.size() < DEPTH && !flush;
    p_set      = bus.wr_valid && mq.size() == DEPTH;
    p_clr      = clr_overflow;
    p_data     = bus.wr_data;
    prev_start = tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (tx_busy === lvl) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (empty && !mdl_busy && !tx_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, int'(ok), 1);
    repeat (3) tick();
  endtask

  typedef struct {
    logic       wv;
    logic [7:0] d;
    logic       fl;
    logic       clr;
    int         lvl;
    logic       full;
    logic       empty;
    logic       rdy;
    logic       ovf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit ok;
    int p0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;

    // Overflow/clear/flush table, applied with uart_tx held busy (no pops).
    tbl[0] = '{1'b1, 8'hFF, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'hFF, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'hFF, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'hFF, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 8'h22, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 8'h33, 1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 8'h44, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset then idle.
    nrst = 1'b0;
    repeat (2) tick();
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_wr_ready", int'(bus.wr_ready), 1);
    chk("reset_level", int'(level), 0);
    chk("reset_tx_start", int'(tx_start), 0);
    chk("reset_overflow", int'(overflow), 0);
    nrst = 1'b1;
    p0 = n_pulses;
    repeat (20) tick();
    chk("idle_no_start", n_pulses - p0, 0);

    // Single byte latency: accepted at the end of cycle N, pulse in cycle N+2.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hA5;
    tick();
    bus.wr_valid = 1'b0;
    chk("lat_n1_start", int'(tx_start), 0);
    tick();
    chk("lat_n2_start", int'(tx_start), 1);
    chk("lat_n2_data", int'(tx_data), 8'hA5);
    tick();
    chk("lat_n3_start", int'(tx_start), 0);
    wait_idle("lat_drain");

    // Burst of 16 bytes; the first pop overlaps the second write.
    p0 = n_pulses;
    for (int i = 0; i < 16; i++) wr_byte(8'(i));
    chk("burst_level", int'(level), 15);
    chk("burst_full", int'(full), 0);
    wait_busy(1'b1, 100, ok);
    chk("b2b_busy_rise", int'(ok), 1);
    wait_busy(1'b0, 100, ok);
    chk("b2b_busy_fall", int'(ok), 1);
    tick();
    chk("b2b_plus1_start", int'(tx_start), 0);
    tick();
    chk("b2b_plus2_start", int'(tx_start), 1);
    chk("b2b_plus2_data", int'(tx_data), 1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (n_pulses - p0 >= 16) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("burst_all_sent", int'(ok), 1);
    wait_idle("burst_drain");
    chk("burst_pulses", n_pulses - p0, 16);

    // Table-driven overflow, clear and flush cases with uart_tx stuck busy.
    force_hi = 1'b1;
    for (int i = 0; i < 16; i++) wr_byte(8'(8'h10 + i));
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 16);
    chk("fill_wr_ready", int'(bus.wr_ready), 0);
    for (int i = 0; i < 10; i++) begin
      bus.wr_valid = tbl[i].wv;
      bus.wr_data  = tbl[i].d;
      flush        = tbl[i].fl;
      clr_overflow = tbl[i].clr;
      tick();
      bus.wr_valid = 1'b0;
      flush        = 1'b0;
      clr_overflow = 1'b0;
      #1;
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].full));
      chk($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].empty));
      chk($sformatf("tbl%0d_wr_ready", i), int'(bus.wr_ready), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_overflow", i), int'(overflow), int'(tbl[i].ovf));
    end
    force_hi = 1'b0;
    wait_idle("tbl_drain");

    // Flush while the first of five bytes is in WAIT_DONE.
    p0 = n_pulses;
    for (int i = 0; i < 5; i++) wr_byte(8'(8'h50 + i));
    wait_busy(1'b1, 20, ok);
    chk("flush_busy_rise", int'(ok), 1);
    repeat (3) tick();
    chk("flush_pre_level", int'(level), 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_level", int'(level), 0);
    chk("flush_empty", int'(empty), 1);
    wait_busy(1'b0, 100, ok);
    chk("flush_busy_fall", int'(ok), 1);
    repeat (10) tick();
    chk("flush_pulses", n_pulses - p0, 1);

    // WAIT_BUSY timeout: busy never rises, next pulse 5 cycles after the first.
    force_lo = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h3C;
    tick();
    bus.wr_data  = 8'hC3;
    tick();
    bus.wr_valid = 1'b0;
    chk("to_first_start", int'(tx_start), 1);
    chk("to_first_data", int'(tx_data), 8'h3C);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("to_gap%0d_start", k), int'(tx_start), 0);
    end
    tick();
    chk("to_second_start", int'(tx_start), 1);
    chk("to_second_data", int'(tx_data), 8'hC3);
    repeat (6) tick();
    chk("to_level", int'(level), 0);
    chk("to_empty", int'(empty), 1);
    wr_byte(8'h5A);
    chk("to_idle_n1_start", int'(tx_start), 0);
    tick();
    chk("to_idle_n2_start", int'(tx_start), 1);
    chk("to_idle_n2_data", int'(tx_data), 8'h5A);
    repeat (6) tick();
    force_lo = 1'b0;
    wait_idle("to_drain");

    // Random traffic with occasional flush, clear and a reset mid-transmission.
    for (int c = 0; c < 1500; c++) begin
      bus.wr_valid = ($urandom_range(0, 1) == 1);
      bus.wr_data  = 8'($urandom_range(0, 254));
      flush        = ($urandom_range(0, 59) == 0);
      clr_overflow = ($urandom_range(0, 29) == 0);
      busy_len     = $urandom_range(3, 12);
      nrst         = (c != 700);
      tick();
    end
    bus.wr_valid = 1'b0;
    flush        = 1'b0;
    clr_overflow = 1'b0;
    nrst         = 1'b1;
    wait_idle("rand_drain");
    chk("ff_never_sent", n_ff, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual %0t required below 1000000", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and transmit sequencer placed directly upstream of uart_tx.
- Accepts bytes from the system on a valid/ready write port and stores them in a synchronous FIFO.
- Feeds the stored bytes one at a time into uart_tx using its tx_data / tx_start / tx_busy handshake.
- Lets producers burst up to DEPTH bytes without waiting on the serial line.

Parameters:
- DEPTH_LOG2, default 4: FIFO depth = 2**DEPTH_LOG2 entries (16 by default); legal range 1..10.

Ports:
- clk  in  1  system clock, all logic on rising edge
- nrst  in  1  synchronous active-low reset
- wr_data  in  8  byte to enqueue
- wr_valid  in  1  producer presents wr_data
- wr_ready  out  1  FIFO can accept; a write occurs when wr_valid && wr_ready
- flush  in  1  synchronous clear of queued (not yet issued) bytes
- clr_overflow  in  1  clears sticky overflow flag
- level  out  DEPTH_LOG2+1  number of queued bytes
- empty  out  1  level == 0
- full  out  1  level == 2**DEPTH_LOG2
- overflow  out  1  sticky: set when wr_valid is asserted while wr_ready is low because of full
- tx_data  out  8  byte to uart_tx, registered
- tx_start  out  1  one-cycle start pulse to uart_tx, registered
- tx_busy  in  1  busy from uart_tx

Behaviour:
- Reset (nrst low at clk edge): state IDLE, read/write pointers 0, level 0, tx_start 0, tx_data 8'h00, overflow 0. Memory contents are don't-care. Derived outputs after reset: empty 1, full 0, wr_ready 1.
- Write side:
  - wr_ready = !full && !flush, derived from registered level.
  - An accepted write stores at wr_ptr; wr_ptr increments modulo depth.
  - A write while full is dropped and sets overflow.
  - clr_overflow clears overflow; a simultaneous set wins.
- Sequencer FSM, states IDLE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if !empty && !tx_busy && !flush, then at the edge: tx_data <= mem[rd_ptr], tx_start <= 1, rd_ptr++, level decrements, go to WAIT_BUSY.
  - WAIT_BUSY: tx_start <= 0 at the first edge, so the pulse is exactly one cycle. Stay until tx_busy is sampled high, then go to WAIT_DONE. uart_tx raises busy the cycle after the pulse, so this state normally lasts 2 cycles.
  - WAIT_BUSY timeout: if tx_busy has not risen within 4 cycles, return to IDLE. The byte is counted as sent (protects against uart_tx being held in reset).
  - WAIT_DONE: when tx_busy is sampled low, go to IDLE.
- Latency: a write accepted in cycle N into an empty FIFO with an idle transmitter gives tx_start high in cycle N+2.
- Back-to-back bytes: the next tx_start is asserted 2 cycles after tx_busy falls (IDLE evaluation cycle, then pulse).
- Simultaneous write and pop in one cycle: both take effect and level is unchanged.
  - When full, wr_ready is low, so a pop does not admit a write in the same cycle.
- Level arithmetic: DEPTH_LOG2+1 bits; +1 on write only, -1 on pop only. Never wraps, as guaranteed by wr_ready and empty.
- Flush:
  - Next edge: rd_ptr <= wr_ptr, level <= 0; a write in the same cycle is dropped (wr_ready is low); pop is suppressed.
  - A byte already issued (WAIT_BUSY/WAIT_DONE) completes normally; the FSM continues its sequence.
- Reset mid-transmission: the FSM returns to IDLE immediately. uart_tx shares nrst, so no stale handshake remains.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_W = 8
  - the sequencer state enum (IDLE, WAIT_BUSY, WAIT_DONE)
  - WAIT_BUSY_TIMEOUT = 4
  - uart_tx uses the same UART_DATA_W.
- One natural sub-module: uart_fifo_ram, a 2**DEPTH_LOG2 x 8 storage array with synchronous write and asynchronous read at rd_ptr.
- Pointers, level, flags and the FSM stay in uart_tx_fifo.

Test Plan:
- Reset then idle: after nrst low for 2 cycles, expect empty=1, full=0, wr_ready=1, level=0, tx_start=0, overflow=0; no tx_start during 20 further cycles.
- Single byte, integrated with uart_tx (BAUD_DIVISOR=4): write 8'hA5 in cycle N -> tx_start high only in cycle N+2 with tx_data=8'hA5; txd shows start bit, bits 1,0,1,0,0,1,0,1 LSB first, then stop bit.
- Burst: write 16 bytes 8'h00..8'h0F on consecutive cycles with DEPTH_LOG2=4 -> full=1 after the last write, or level 15 if the first pop overlaps. All 16 bytes appear on txd in order; exactly 16 tx_start pulses, each one cycle wide.
- Overflow: with uart_tx busy and FIFO full, hold wr_valid high with 8'hFF for 3 cycles -> wr_ready=0, level unchanged, overflow=1. Pulse clr_overflow -> overflow=0; 8'hFF is never transmitted.
- Flush mid-stream: queue 5 bytes, assert flush while the first byte is in WAIT_DONE -> that first byte completes on txd; level=0 next cycle; no further tx_start.
- Timeout: tie tx_busy low externally, write 8'h3C -> one tx_start pulse, FSM returns to IDLE 4 cycles later, level=0, empty=1.
